// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C target.
// SCL/SDA are oversampled on clk; START/STOP and SCL edges become one-clk
// strobes. SDA is only ever pulled low (sda_oe=1) or released, and it only
// changes on the clk after a synchronized SCL falling edge.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'b0010000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_taken,
  output logic       addr_hit,
  output logic       rw_o,
  output logic       stop_det,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_BYTE   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_e;

  // [0],[1] synchronize, [2] holds the previous synchronized value
  logic [2:0] scl_sync_q;
  logic [2:0] sda_sync_q;

  state_e     state_q,    state_d;
  logic [2:0] bit_cnt_q,  bit_cnt_d;
  logic       byte_full_q, byte_full_d;  // 8th bit of the byte has been clocked
  logic [7:0] shift_q,    shift_d;
  logic       nack_q,     nack_d;
  logic       sda_oe_q,   sda_oe_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_taken_q, tx_taken_d;
  logic       addr_hit_q, addr_hit_d;
  logic       rw_q,       rw_d;
  logic       stop_det_q, stop_det_d;
  logic       busy_q,     busy_d;

  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, start_s, stop_s;

  assign scl_s    = scl_sync_q[1];
  assign scl_p    = scl_sync_q[2];
  assign sda_s    = sda_sync_q[1];
  assign sda_p    = sda_sync_q[2];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start_s  = scl_s & sda_p & ~sda_s;
  assign stop_s   = scl_s & ~sda_p & sda_s;

  // Pad synchronizers plus edge-detect history flop; idle bus level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl_i};
      sda_sync_q <= {sda_sync_q[1:0], sda_i};
    end
  end

  // Protocol state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_full_q <= 1'b0;
      shift_q     <= 8'h00;
      nack_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_taken_q  <= 1'b0;
      addr_hit_q  <= 1'b0;
      rw_q        <= 1'b0;
      stop_det_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_full_q <= byte_full_d;
      shift_q     <= shift_d;
      nack_q      <= nack_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_taken_q  <= tx_taken_d;
      addr_hit_q  <= addr_hit_d;
      rw_q        <= rw_d;
      stop_det_q  <= stop_det_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: STOP beats START beats SCL edges.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_full_d = byte_full_q;
    shift_d     = shift_q;
    nack_d      = nack_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_taken_d  = 1'b0;
    addr_hit_d  = 1'b0;
    rw_d        = rw_q;
    stop_det_d  = 1'b0;
    busy_d      = busy_q;

    if (stop_s) begin
      state_d     = ST_IDLE;
      sda_oe_d    = 1'b0;
      stop_det_d  = 1'b1;
      busy_d      = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_full_d = 1'b0;
    end else if (start_s) begin
      // START or repeated START: busy is left as it is
      state_d     = ST_ADDR;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_full_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise && !byte_full_q) begin
            shift_d     = {shift_q[6:0], sda_s};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_full_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall && byte_full_q) begin
            bit_cnt_d   = 3'd0;
            byte_full_d = 1'b0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d    = ST_ADDR_ACK;
              sda_oe_d   = 1'b1;
              rw_d       = shift_q[0];
              addr_hit_d = 1'b1;
              busy_d     = 1'b1;
            end else begin
              state_d  = ST_WAIT_STOP;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end

        ST_ADDR_ACK: begin
          // fall at the end of the 9th clock ends our ACK
          if (scl_fall) begin
            bit_cnt_d   = 3'd0;
            byte_full_d = 1'b0;
            if (rw_q) begin
              state_d    = ST_TX_BYTE;
              shift_d    = tx_data;
              tx_taken_d = 1'b1;
              sda_oe_d   = ~tx_data[7];
            end else begin
              state_d  = ST_RX_BYTE;
              sda_oe_d = 1'b0;
            end
          end else begin
            state_d = ST_ADDR_ACK;
          end
        end

        ST_RX_BYTE: begin
          if (scl_rise && !byte_full_q) begin
            shift_d     = {shift_q[6:0], sda_s};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_full_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall && byte_full_q) begin
            state_d     = ST_RX_ACK;
            rx_data_d   = shift_q;
            rx_valid_d  = 1'b1;
            sda_oe_d    = 1'b1;
            bit_cnt_d   = 3'd0;
            byte_full_d = 1'b0;
          end else begin
            state_d = ST_RX_BYTE;
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            state_d  = ST_RX_BYTE;
            sda_oe_d = 1'b0;
          end else begin
            state_d = ST_RX_ACK;
          end
        end

        ST_TX_BYTE: begin
          if (scl_rise && !byte_full_q) begin
            bit_cnt_d   = bit_cnt_q + 3'd1;
            byte_full_d = (bit_cnt_q == 3'd7);
          end else if (scl_fall) begin
            if (byte_full_q) begin
              // release SDA so the master can drive its ACK
              state_d     = ST_TX_ACK;
              sda_oe_d    = 1'b0;
              bit_cnt_d   = 3'd0;
              byte_full_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end else begin
            state_d = ST_TX_BYTE;
          end
        end

        ST_TX_ACK: begin
          if (scl_rise) begin
            nack_d = sda_s;
          end else if (scl_fall) begin
            if (nack_q) begin
              state_d  = ST_WAIT_STOP;
              sda_oe_d = 1'b0;
            end else begin
              state_d    = ST_TX_BYTE;
              shift_d    = tx_data;
              tx_taken_d = 1'b1;
              sda_oe_d   = ~tx_data[7];
            end
          end else begin
            state_d = ST_TX_ACK;
          end
        end

        ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_taken = tx_taken_q;
  assign addr_hit = addr_hit_q;
  assign rw_o     = rw_q;
  assign stop_det = stop_det_q;
  assign busy     = busy_q;

endmodule
